flip_tx_rt: RTL
===============

Name: flip_tx_rt

Overview:
Transmit-side companion of the FPU input flip buffers: the sender end of the en/pause/delayed-data link.
- Accepts words from a local producer through a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Issues them downstream as a one-cycle tx_en strobe; the data word follows exactly two cycles later, matching the receiver's two-stage data capture.
- Honours the receiver's combinational tx_pause.

Parameters:
WIDTH, 32, data word width
DEPTH, 4, FIFO entries; power of two, 2..16

Ports:
clk  input  1  clock
rst  input  1  reset
src_valid  input  1  producer offers src_data
src_data  input  WIDTH  producer word
src_ready  output  1  FIFO can accept this cycle
tx_en  output  1  downstream strobe; one word per asserted cycle
tx_data  output  WIDTH  word belonging to the tx_en asserted two cycles earlier
tx_dvalid  output  1  tx_data carries a word this cycle
tx_pause  input  1  receiver backpressure, combinational from receiver
count  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset clears:
  - FIFO pointers and count to 0
  - both data pipeline stages, including valid bits, to 0
  - tx_data to 0 and tx_dvalid to 0
- After reset, src_ready=1 and tx_en=0.
- Push:
  - src_ready = (count != DEPTH), decoded from registered count only; no combinational path from tx_pause or pop.
  - Push occurs when src_valid && src_ready; the word is written at the write pointer.
- Pop:
  - tx_en = (count != 0) && !tx_pause. This is the only combinational path, tx_pause -> tx_en.
  - Pop occurs when tx_en=1: read pointer advances, and mem[rd_ptr] is captured into pipe stage 1 with its valid bit set.
- Data pipeline:
  - Stage 1 -> stage 2 every cycle, unconditionally; the pipeline is never stalled by pause.
  - tx_data / tx_dvalid are the stage-2 register outputs.
  - When stage-2 valid=0, tx_data holds its previous value.
- Latency:
  - Accept at cycle T -> tx_en earliest at T+1 (no bypass) -> tx_data/tx_dvalid at T+3.
  - tx_en at cycle N always yields tx_dvalid=1 at N+2. This is fixed and independent of tx_pause at N+1 or N+2.
- Pointers:
  - Width $clog2(DEPTH); wrap from DEPTH-1 to 0.
  - count is updated by +1 on push only, -1 on pop only, and is unchanged on push and pop together.
- Boundary conditions:
  - Full (count=DEPTH) with pop in the same cycle: no push; src_ready reasserts the next cycle.
  - Empty with push: no pop that cycle; the word is visible the next cycle.
  - tx_pause held high: tx_en=0, the FIFO fills to DEPTH, then src_ready=0. Words already in the pipeline still emerge.
  - tx_pause toggling every cycle: tx_en follows !tx_pause whenever count>0, and order is preserved.
- Reset mid-operation: in-flight pipeline words and FIFO contents are discarded. tx_dvalid=0 from the cycle after the rst edge.
- Ordering: strict FIFO. No word is duplicated or dropped.

Optional Feature:
Macro: FLIP_TX_BYPASS_EN
- With the macro defined:
  - When count=0, src_valid=1 and tx_pause=0, the word goes straight to pipe stage 1 and tx_en asserts in the same cycle; the FIFO is not written.
  - Accept-to-data latency is 2 cycles.
  - src_ready remains count-based.
- Without the macro: no bypass; minimum accept-to-data latency is 3 cycles.

Test Plan:
- Reset, then push 0xA5A5A5A5 at cycle 5 with tx_pause=0:
  - tx_en=1 at cycle 6, tx_data=0xA5A5A5A5 with tx_dvalid=1 at cycle 8.
  - With FLIP_TX_BYPASS_EN: tx_en at cycle 5, data at cycle 7.
- tx_pause=1 and push 6 words 1..6 back-to-back:
  - Words 1..4 are accepted and src_ready=0 after the 4th; count=4, tx_en=0 throughout.
  - Release pause: tx_en for 4 cycles, tx_data 1,2,3,4 in order.
  - Words 5 and 6 are accepted once src_ready returns and emerge as 5,6.
- count=4, push held, tx_pause=0: a pop occurs with no push that cycle; count=3 next cycle, src_ready=1; then sustained 1/cycle throughput.
- tx_pause alternating 1/0 with 8 queued words 0x10..0x17: tx_en only in pause=0 cycles; each tx_dvalid is exactly 2 cycles after its tx_en, values sequential.
- tx_pause rises the cycle after a tx_en: the word from that tx_en still appears with tx_dvalid=1 two cycles later.
- rst asserted with 3 queued words and 2 words in the pipeline: the next cycle count=0, tx_dvalid=0, tx_data=0, src_ready=1; no stale word appears afterwards.

Source files
------------

// File: rtl/flip_tx_rt.sv
// flip_tx_rt: transmit end of the en/pause/delayed-data link.
// Buffers producer words in a DEPTH-entry FIFO and sends them as a one-cycle
// tx_en strobe. The matching word appears on tx_data exactly two cycles later.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   src_valid/src_data  producer offer
//   src_ready           FIFO not full (decoded from registered count)
//   tx_en               pop strobe, combinational from tx_pause
//   tx_data/tx_dvalid   stage-2 data register and its valid bit
//   tx_pause            receiver backpressure (combinational from receiver)
//   count               FIFO occupancy
//
// Optional build macro FLIP_TX_BYPASS_EN: when the FIFO is empty and the
// link is not paused, an offered word skips the FIFO and goes straight to
// stage 1. This gives 2-cycle accept-to-data latency.
module flip_tx_rt #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       src_valid,
    input  logic [WIDTH-1:0]           src_data,
    output logic                       src_ready,
    output logic                       tx_en,
    output logic [WIDTH-1:0]           tx_data,
    output logic                       tx_dvalid,
    input  logic                       tx_pause,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic             s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0] s2_data_q, s2_data_d;
    logic             s2_vld_q, s2_vld_d;

    logic byp;
    logic push;
    logic pop;

`ifdef FLIP_TX_BYPASS_EN
    assign byp = (count_q == '0) && src_valid && !tx_pause;
`else
    assign byp = 1'b0;
`endif

    // src_ready depends only on registered state; tx_pause reaches tx_en only
    assign src_ready = (count_q != CW'(DEPTH));
    assign tx_en     = !tx_pause && ((count_q != '0) || byp);
    assign push      = src_valid && src_ready && !byp;
    assign pop       = tx_en && !byp;

    assign count     = count_q;
    assign tx_data   = s2_data_q;
    assign tx_dvalid = s2_vld_q;

    // Pointer, occupancy and data-pipeline next state
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        s1_data_d = s1_data_q;
        s1_vld_d  = tx_en;
        s2_vld_d  = s1_vld_q;
        s2_data_d = s2_data_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (tx_en) s1_data_d = byp ? src_data : mem_q[rd_ptr_q];
        // Stage 2 always advances; tx_data keeps its last word when idle
        if (s1_vld_q) s2_data_d = s1_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            s1_data_q <= '0;
            s1_vld_q  <= 1'b0;
            s2_data_q <= '0;
            s2_vld_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            s1_data_q <= s1_data_d;
            s1_vld_q  <= s1_vld_d;
            s2_data_q <= s2_data_d;
            s2_vld_q  <= s2_vld_d;
        end
    end

    // Storage array: no reset, since contents are qualified by count
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= src_data;
    end

endmodule
